alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that runs 16x16 unsigned multiply (32-bit product) and divide (quotient and remainder) on the CPU's existing 16-bit ALU.
- Issues one ALU add or subtract per cycle and keeps the shift registers locally.
- Sits beside the ALU in the execute stage. The parent instantiates the ALU once and wires this block's Alu* outputs to its A/B/ALUOp/BNegate inputs; a parent mux gives this block the ALU while Busy is high.

Parameters:
- WIDTH, 16, operand width; must match the ALU width.
- ITER, 16, iterations per operation; equals WIDTH.
- CNT_W, 5, iteration counter width; must hold ITER.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; accepted only in IDLE or DONE.
- Op  in  2  00 MULU, 01 DIVU, 10 MULS, 11 DIVS (the signed codes need the optional feature).
- OperandA  in  16  multiplicand / dividend.
- OperandB  in  16  multiplier / divisor.
- Busy  out  1  high in RUN (and SIGN).
- Done  out  1  high for exactly the one cycle spent in DONE.
- ResultHi  out  16  product[31:16] / remainder.
- ResultLo  out  16  product[15:0] / quotient.
- DivByZero  out  1  set by a divide with OperandB==0; held until the next accepted Start.
- AluA  out  16  ALU A operand.
- AluB  out  16  ALU B operand.
- AluOp  out  2  ALU operation select.
- AluBNegate  out  1  ALU B-invert plus carry-in.
- AluResult  in  16  ALU Result.
- AluCarryOut  in  1  ALU CarryOut.

Behaviour:
- ALUOp encoding: 00 AND, 01 OR, 10 ADD, 11 SLT. ADD with BNegate=1 is SUB; on SUB, CarryOut=1 means A>=B unsigned.
- Reset: state IDLE. Busy, Done, DivByZero, ResultHi, ResultLo, counter all 0. Reset mid-operation aborts immediately with no Done.
- ALU outputs outside RUN: AluA=0, AluB=0, AluOp=ADD, AluBNegate=0.
- States: IDLE, RUN, DONE (plus SIGN with the optional feature).
  - IDLE/DONE with Start: load Hi, Lo, D and counter=0, clear DivByZero, go to RUN.
  - DONE without Start: go to IDLE.
  - RUN with counter==ITER-1: go to DONE after the iteration completes.
- Divide by zero: if Start is accepted with Op=DIVU and OperandB==0, go straight to DONE with ResultLo=0xFFFF, ResultHi=OperandA, DivByZero=1. Done is high the cycle after Start.
- MULU load: Hi=0, Lo=OperandB, D=OperandA. Each RUN cycle:
  - Lo[0]=1: AluA=Hi, AluB=D, ADD, BNegate=0; then {Hi,Lo} <= {AluCarryOut, AluResult, Lo[15:1]}.
  - Lo[0]=0: {Hi,Lo} <= {1'b0, Hi, Lo[15:1]}.
- DIVU load: Hi=0, Lo=OperandA, D=OperandB. Each RUN cycle:
  - Form shifted remainder S={Hi[14:0],Lo[15]}, with msb=Hi[15].
  - Drive AluA=S, AluB=D, ADD, BNegate=1.
  - If msb|AluCarryOut: Hi<=AluResult and shift in quotient bit 1. Else Hi<=S and shift in 0. Lo<={Lo[14:0],qbit}.
- Latency: Start accepted at edge k; the 16 iterations occur at edges k+1..k+16; Done is high the cycle after edge k+16.
- Back-to-back operation: Start during DONE is accepted, Done still lasts one cycle, and the next result follows 17 cycles later.
- Start while Busy is ignored.
- Result validity: ResultHi/ResultLo are valid while Done is high and held until the next accepted Start. Their intermediate values during RUN are undefined for the consumer.
- Without the feature, Op[1] is ignored: MULS/DIVS execute as MULU/DIVU.

Optional Feature:
- Macro: ALU_MULDIV_SIGNED_EN.
- Defined:
  - MULS/DIVS load the absolute values of the operands (local negation) and record the result signs.
  - The unsigned RUN proceeds unchanged.
  - One extra SIGN state negates the 32-bit product, or the quotient, when the signs differ. The remainder takes the dividend's sign.
  - Signed latency is 18 cycles to Done.
  - Signed divide by zero: Quot=0xFFFF, Rem=OperandA.
- Undefined: SIGN state is absent and signed Op codes are treated as unsigned.

Decomposition:
- Package alu_muldiv_pkg holds:
  - ALUOP_AND/OR/ADD/SLT constants;
  - OP_MULU/DIVU/MULS/DIVS codes;
  - the state encoding (IDLE, RUN, DONE, SIGN);
  - ITER.
- No sub-module: the iteration step is plain next-state logic, and the sign fix-up is a local function. The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- MULU 0x1234 x 0x5678 -> Hi=0x0626, Lo=0x0060; Done exactly 17 cycles after Start; Busy high for 16 cycles.
- MULU 0xFFFF x 0xFFFF -> Hi=0xFFFE, Lo=0x0001; AluCarryOut path exercised.
- DIVU 1000 / 7 -> Lo=0x008E, Hi=0x0006. DIVU 0xFFFF / 0x8001 -> Lo=0x0001, Hi=0x7FFE (msb path).
- DIVU 0x1234 / 0 -> Lo=0xFFFF, Hi=0x1234, DivByZero=1; Done one cycle after Start; a following MULU Start clears DivByZero.
- Reset asserted at iteration 8, then Start re-pulsed during RUN and at DONE -> reset gives IDLE with all outputs 0 and no Done; Start during RUN is ignored; Start at DONE is accepted back-to-back.
- With ALU_MULDIV_SIGNED_EN: MULS 0xFFFE x 0x0003 -> 0xFFFF_FFFA; DIVS 0xFFF9 / 0x0002 -> Q=0xFFFD, R=0xFFFF; Done at 18 cycles.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU opcodes, operation codes and FSM encoding for the multiply/divide sequencer.
package alu_muldiv_pkg;
    localparam int ITER = 16;

    localparam logic [1:0] ALUOP_AND = 2'b00;
    localparam logic [1:0] ALUOP_OR  = 2'b01;
    localparam logic [1:0] ALUOP_ADD = 2'b10;
    localparam logic [1:0] ALUOP_SLT = 2'b11;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_MULS = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10,
        ST_SIGN = 2'b11
    } state_t;
endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/result bus plus the borrowed-ALU port of the multiply/divide sequencer.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_operand_a;
    logic [WIDTH-1:0] i_operand_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result_hi;
    logic [WIDTH-1:0] o_result_lo;
    logic             o_div_by_zero;
    logic [WIDTH-1:0] o_alu_a;
    logic [WIDTH-1:0] o_alu_b;
    logic [1:0]       o_alu_op;
    logic             o_alu_b_negate;
    logic [WIDTH-1:0] i_alu_result;
    logic             i_alu_carry_out;

    modport slave (
        input  i_start, i_op, i_operand_a, i_operand_b, i_alu_result, i_alu_carry_out,
        output o_busy, o_done, o_result_hi, o_result_lo, o_div_by_zero,
        output o_alu_a, o_alu_b, o_alu_op, o_alu_b_negate
    );

    modport master (
        output i_start, i_op, i_operand_a, i_operand_b, i_alu_result, i_alu_carry_out,
        input  o_busy, o_done, o_result_hi, o_result_lo, o_div_by_zero,
        input  o_alu_a, o_alu_b, o_alu_op, o_alu_b_negate
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Borrows the shared ALU for one add/sub per cycle: shift-add multiply, restoring divide.
// Define ALU_MULDIV_SIGNED_EN to add MULS/DIVS (abs-value load plus a SIGN fix-up state).
module alu_muldiv_seq #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16,
    parameter int CNT_W = 5
) (
    input logic             i_clk,
    input logic             i_rst,
    alu_muldiv_seq_if.slave bus
);
    import alu_muldiv_pkg::*;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_hi, r_lo, r_d;
    logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt, w_d_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_dbz, w_dbz_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic [WIDTH-1:0] w_shift, w_ld_a, w_ld_b;
    logic             w_q, w_last;
    logic [WIDTH-1:0] w_alu_a, w_alu_b;
    logic [1:0]       w_alu_op;
    logic             w_alu_bneg;

`ifdef ALU_MULDIV_SIGNED_EN
    logic r_sgn, r_neg_q, r_neg_r;
    logic w_sgn_nxt, w_neg_q_nxt, w_neg_r_nxt;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    // Signed ops run the unsigned datapath on magnitudes; 0x8000 stays 0x8000 as unsigned.
    assign w_ld_a = f_neg(bus.i_operand_a, bus.i_op[1] & bus.i_operand_a[WIDTH-1]);
    assign w_ld_b = f_neg(bus.i_operand_b, bus.i_op[1] & bus.i_operand_b[WIDTH-1]);
`else
    assign w_ld_a = bus.i_operand_a;
    assign w_ld_b = bus.i_operand_b;
`endif

    assign w_last = (r_cnt == CNT_W'(ITER - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_d_nxt      = r_d;
        w_cnt_nxt    = r_cnt;
        w_dbz_nxt    = r_dbz;
        w_is_div_nxt = r_is_div;
`ifdef ALU_MULDIV_SIGNED_EN
        w_sgn_nxt    = r_sgn;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
`endif
        w_alu_a      = '0;
        w_alu_b      = '0;
        w_alu_op     = ALUOP_ADD;
        w_alu_bneg   = 1'b0;
        w_shift      = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
        w_q          = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    w_cnt_nxt    = '0;
                    w_dbz_nxt    = 1'b0;
                    w_is_div_nxt = bus.i_op[0];
                    w_hi_nxt     = '0;
                    w_state_nxt  = ST_RUN;
`ifdef ALU_MULDIV_SIGNED_EN
                    w_sgn_nxt    = bus.i_op[1];
                    w_neg_q_nxt  = bus.i_op[1] & (bus.i_operand_a[WIDTH-1] ^ bus.i_operand_b[WIDTH-1]);
                    w_neg_r_nxt  = bus.i_op[1] & bus.i_operand_a[WIDTH-1];
`endif
                    if (bus.i_op[0] && (bus.i_operand_b == '0)) begin
                        w_hi_nxt    = bus.i_operand_a;
                        w_lo_nxt    = '1;
                        w_dbz_nxt   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (bus.i_op[0]) begin
                        w_lo_nxt = w_ld_a;
                        w_d_nxt  = w_ld_b;
                    end else begin
                        w_lo_nxt = w_ld_b;
                        w_d_nxt  = w_ld_a;
                    end
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RUN: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_is_div) begin
                    // Hi[15] set means the 17-bit shifted remainder already exceeds any divisor.
                    w_alu_a    = w_shift;
                    w_alu_b    = r_d;
                    w_alu_bneg = 1'b1;
                    w_q        = r_hi[WIDTH-1] | bus.i_alu_carry_out;
                    w_hi_nxt   = w_q ? bus.i_alu_result : w_shift;
                    w_lo_nxt   = {r_lo[WIDTH-2:0], w_q};
                end else begin
                    w_alu_a = r_hi;
                    w_alu_b = r_d;
                    if (r_lo[0]) begin
                        {w_hi_nxt, w_lo_nxt} = {bus.i_alu_carry_out, bus.i_alu_result, r_lo[WIDTH-1:1]};
                    end else begin
                        {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
                    end
                end
                if (w_last) begin
`ifdef ALU_MULDIV_SIGNED_EN
                    w_state_nxt = r_sgn ? ST_SIGN : ST_DONE;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end

`ifdef ALU_MULDIV_SIGNED_EN
            ST_SIGN: begin
                if (r_is_div) begin
                    w_lo_nxt = f_neg(r_lo, r_neg_q);
                    w_hi_nxt = f_neg(r_hi, r_neg_r);
                end else begin
                    {w_hi_nxt, w_lo_nxt} = f_neg2({r_hi, r_lo}, r_neg_q);
                end
                w_state_nxt = ST_DONE;
            end
`endif

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_d      <= '0;
            r_cnt    <= '0;
            r_dbz    <= 1'b0;
            r_is_div <= 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
            r_sgn    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_d      <= w_d_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dbz    <= w_dbz_nxt;
            r_is_div <= w_is_div_nxt;
`ifdef ALU_MULDIV_SIGNED_EN
            r_sgn    <= w_sgn_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
`endif
        end
    end

    assign bus.o_busy         = (r_state == ST_RUN) || (r_state == ST_SIGN);
    assign bus.o_done         = (r_state == ST_DONE);
    assign bus.o_result_hi    = r_hi;
    assign bus.o_result_lo    = r_lo;
    assign bus.o_div_by_zero  = r_dbz;
    assign bus.o_alu_a        = w_alu_a;
    assign bus.o_alu_b        = w_alu_b;
    assign bus.o_alu_op       = w_alu_op;
    assign bus.o_alu_b_negate = w_alu_bneg;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: a behavioural ALU, an arithmetic reference model checked every
// cycle, and directed vectors with hand-computed results and latencies.
module tb_alu_muldiv_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_muldiv_seq_if #(.WIDTH(W)) bus_if ();

    alu_muldiv_seq #(.WIDTH(W), .ITER(16), .CNT_W(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // The parent's ALU: AND / OR / ADD / SLT with B-invert plus carry-in.
    logic [W-1:0] alu_beff;
    logic [W:0]   alu_sum;
    always_comb begin
        alu_beff = bus_if.o_alu_b_negate ? ~bus_if.o_alu_b : bus_if.o_alu_b;
        alu_sum  = {1'b0, bus_if.o_alu_a} + {1'b0, alu_beff} + {{W{1'b0}}, bus_if.o_alu_b_negate};
        case (bus_if.o_alu_op)
            2'b00:   bus_if.i_alu_result = bus_if.o_alu_a & alu_beff;
            2'b01:   bus_if.i_alu_result = bus_if.o_alu_a | alu_beff;
            2'b10:   bus_if.i_alu_result = alu_sum[W-1:0];
            default: bus_if.i_alu_result = {{(W-1){1'b0}}, alu_sum[W-1]};
        endcase
        bus_if.i_alu_carry_out = alu_sum[W];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: what an operation must return, and how many busy cycles it takes.
    function automatic void model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] hi, output logic [W-1:0] lo,
                                     output logic dbz, output int busy_cycles);
        logic        sgn;
        logic [31:0] p;
        int          sa, sb;
`ifdef ALU_MULDIV_SIGNED_EN
        sgn = op[1];
`else
        sgn = 1'b0;
`endif
        sa  = $signed(a);
        sb  = $signed(b);
        dbz = 1'b0;
        busy_cycles = sgn ? 17 : 16;
        if (op[0] && b == '0) begin
            hi = a;
            lo = 16'hFFFF;
            dbz = 1'b1;
            busy_cycles = 0;
        end else if (!op[0]) begin
            p  = sgn ? 32'(sa * sb) : ({16'd0, a} * {16'd0, b});
            hi = p[31:16];
            lo = p[15:0];
        end else if (sgn) begin
            lo = 16'(sa / sb);
            hi = 16'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    logic         m_busy, m_done, m_dbz, m_valid;
    logic [W-1:0] m_hi, m_lo, m_phi, m_plo;
    int           m_left;

    always @(posedge clk) begin
        logic [W-1:0] hi, lo;
        logic         dbz;
        int           bc;
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; m_valid <= 1'b1;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_valid <= 1'b1;
                m_hi <= m_phi; m_lo <= m_plo;
            end
        end else if (bus_if.i_start) begin
            model_op(bus_if.i_op, bus_if.i_operand_a, bus_if.i_operand_b, hi, lo, dbz, bc);
            m_dbz <= dbz;
            m_phi <= hi;
            m_plo <= lo;
            if (dbz) begin
                m_done <= 1'b1; m_valid <= 1'b1; m_hi <= hi; m_lo <= lo;
            end else begin
                m_done <= 1'b0; m_busy <= 1'b1; m_valid <= 1'b0; m_left <= bc;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, bus_if.o_busy}, {31'd0, m_busy});
            check("done", {31'd0, bus_if.o_done}, {31'd0, m_done});
            check("div_by_zero", {31'd0, bus_if.o_div_by_zero}, {31'd0, m_dbz});
            if (m_valid) begin
                check("result_hi", {16'd0, bus_if.o_result_hi}, {16'd0, m_hi});
                check("result_lo", {16'd0, bus_if.o_result_lo}, {16'd0, m_lo});
            end
            if (!m_busy) begin
                check("idle alu_a", {16'd0, bus_if.o_alu_a}, 32'd0);
                check("idle alu_b", {16'd0, bus_if.o_alu_b}, 32'd0);
                check("idle alu_op", {30'd0, bus_if.o_alu_op}, 32'd2);
                check("idle alu_b_negate", {31'd0, bus_if.o_alu_b_negate}, 32'd0);
            end
        end
    end

    task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus_if.i_start     = 1'b1;
        bus_if.i_op        = op;
        bus_if.i_operand_a = a;
        bus_if.i_operand_b = b;
    endtask

    // Called one negedge after the Start cycle; t counts cycles since Start.
    task automatic wait_done(input string name, output int t, output int busy_cnt);
        bit seen;
        seen = 0;
        t = 1;
        busy_cnt = 0;
        while (!seen && t <= 40) begin
            if (bus_if.o_done) seen = 1;
            else begin
                if (bus_if.o_busy) busy_cnt++;
                @(negedge clk);
                t++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles, required one", name, t);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edbz, input int elat);
        int t, bc;
        @(negedge clk);
        drive_start(op, a, b);
        @(negedge clk);
        bus_if.i_start = 1'b0;
        wait_done(name, t, bc);
        check({name, " latency"}, t, elat);
        check({name, " busy cycles"}, bc, elat - 1);
        check({name, " hi"}, {16'd0, bus_if.o_result_hi}, {16'd0, ehi});
        check({name, " lo"}, {16'd0, bus_if.o_result_lo}, {16'd0, elo});
        check({name, " dbz"}, {31'd0, bus_if.o_div_by_zero}, {31'd0, edbz});
    endtask

    initial begin
        int t, bc, ndone;
        bus_if.i_start     = 1'b0;
        bus_if.i_op        = 2'b00;
        bus_if.i_operand_a = '0;
        bus_if.i_operand_b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", {31'd0, bus_if.o_busy}, 32'd0);
        check("reset done", {31'd0, bus_if.o_done}, 32'd0);
        check("reset hi", {16'd0, bus_if.o_result_hi}, 32'd0);
        check("reset lo", {16'd0, bus_if.o_result_lo}, 32'd0);
        check("reset dbz", {31'd0, bus_if.o_div_by_zero}, 32'd0);
        rst = 1'b0;

        run_op("mulu 1234x5678", 2'b00, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 17);
        run_op("mulu ffffxffff", 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17);
        run_op("divu 1000/7", 2'b01, 16'd1000, 16'd7, 16'h0006, 16'h008E, 1'b0, 17);
        run_op("divu ffff/8001", 2'b01, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17);
        run_op("divu by zero", 2'b01, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1);
        run_op("mulu clears dbz", 2'b00, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 17);
        run_op("divu small/large", 2'b01, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, 17);
`ifdef ALU_MULDIV_SIGNED_EN
        run_op("muls fffex0003", 2'b10, 16'hFFFE, 16'h0003, 16'hFFFF, 16'hFFFA, 1'b0, 18);
        run_op("divs fff9/0002", 2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 18);
        run_op("divs by zero", 2'b11, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1, 1);
`else
        run_op("muls as mulu", 2'b10, 16'hFFFE, 16'h0003, 16'h0002, 16'hFFFA, 1'b0, 17);
        run_op("divs as divu", 2'b11, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0, 17);
`endif

        // Abort mid-operation with reset; no Done may follow.
        @(negedge clk);
        drive_start(2'b00, 16'h00FF, 16'h0101);
        @(negedge clk);
        bus_if.i_start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, bus_if.o_busy}, 32'd0);
        check("abort hi", {16'd0, bus_if.o_result_hi}, 32'd0);
        check("abort lo", {16'd0, bus_if.o_result_lo}, 32'd0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.o_done) ndone++;
        end
        check("abort no done", ndone, 0);

        // Start during RUN is ignored; Start in the DONE cycle is taken back-to-back.
        drive_start(2'b00, 16'h0007, 16'h0009);
        @(negedge clk);
        bus_if.i_start = 1'b0;
        repeat (4) @(negedge clk);
        drive_start(2'b01, 16'd100, 16'd7);
        @(negedge clk);
        bus_if.i_start = 1'b0;
        wait_done("ignored start", t, bc);
        check("ignored start latency", t, 12);
        check("ignored start lo", {16'd0, bus_if.o_result_lo}, 32'h3F);
        check("ignored start hi", {16'd0, bus_if.o_result_hi}, 32'h0);
        drive_start(2'b01, 16'd1000, 16'd7);
        @(negedge clk);
        bus_if.i_start = 1'b0;
        check("b2b done one cycle", {31'd0, bus_if.o_done}, 32'd0);
        check("b2b busy", {31'd0, bus_if.o_busy}, 32'd1);
        wait_done("back to back", t, bc);
        check("b2b latency", t, 17);
        check("b2b lo", {16'd0, bus_if.o_result_lo}, 32'h8E);
        check("b2b hi", {16'd0, bus_if.o_result_hi}, 32'h6);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
